// File: rtl/ps2_scancode_rx.sv
// ---------------------------------------------------------------------------
// ps2_scancode_rx
//   Deframes the raw PS/2 keyboard stream into 8-bit scan codes. The 0xE0
//   (extended) and 0xF0 (break) prefix bytes are absorbed and attached as
//   flags to the next code byte.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   ps2_clk      raw PS/2 clock pin (asynchronous to clk)
//   ps2_data     raw PS/2 data pin (asynchronous to clk)
//   scan_code    last accepted code byte, held until the next one
//   is_break     scan_code was preceded by 0xF0
//   is_extended  scan_code was preceded by 0xE0
//   code_valid   one-cycle pulse when a new non-prefix byte is presented
//   frame_err    one-cycle pulse on parity, stop-bit or timeout error
// ---------------------------------------------------------------------------
module ps2_scancode_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       is_break,
  output logic       is_extended,
  output logic       code_valid,
  output logic       frame_err
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic              clk_prev;
  logic              clk_s, data_s, fe;
  logic [2:0]        bitcnt;
  logic [7:0]        shreg;
  logic              par_q;
  logic [TW-1:0]     tcnt;
  logic              ext_pending, brk_pending;
  logic              stop_fe, timeout, frame_ok, accept, bad;

  // Synchronisers reset to 1 so the idle-high line never produces a
  // spurious falling edge coming out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so every flop
      // samples the pre-edge value; blocking here would collapse the chain.
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_s;
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fe     = clk_prev & ~clk_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: every comb output gets a default first; otherwise a path that
    // skips an assignment infers a latch.
    state_d = state_q;
    stop_fe = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE:   if (fe && !data_s)          state_d = DATA;  // data=1 is a glitch
      DATA:   if (fe && bitcnt == 3'd7)   state_d = PARITY;
      PARITY: if (fe)                     state_d = STOP;
      STOP:   if (fe) begin
                state_d = IDLE;
                stop_fe = 1'b1;
              end
      default:                            state_d = IDLE;
    endcase
    // An edge in the threshold cycle wins over the timeout.
    if (state_q != IDLE && !fe && tcnt == TIMEOUT_LAST) begin
      timeout = 1'b1;
      state_d = IDLE;
    end
  end

  // Odd parity over data+parity, and the stop bit (current data) must be 1.
  assign frame_ok = (^{shreg, par_q}) & data_s;
  assign accept   = stop_fe & frame_ok;
  assign bad      = (stop_fe & ~frame_ok) | timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitcnt      <= '0;
      shreg       <= '0;
      par_q       <= 1'b0;
      tcnt        <= '0;
      ext_pending <= 1'b0;
      brk_pending <= 1'b0;
      scan_code   <= '0;
      is_break    <= 1'b0;
      is_extended <= 1'b0;
      code_valid  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= bad;

      if (state_q == IDLE || fe) tcnt <= '0;
      else                       tcnt <= tcnt + TW'(1);

      if (fe) begin
        case (state_q)
          IDLE:    bitcnt <= '0;
          DATA: begin
            shreg  <= {data_s, shreg[7:1]};   // LSB arrives first
            bitcnt <= bitcnt + 3'd1;
          end
          PARITY:  par_q <= data_s;
          default: ;
        endcase
      end

      if (bad) begin
        ext_pending <= 1'b0;
        brk_pending <= 1'b0;
      end else if (accept) begin
        if (shreg == 8'hE0) begin
          ext_pending <= 1'b1;
        end else if (shreg == 8'hF0) begin
          brk_pending <= 1'b1;
        end else begin
          scan_code   <= shreg;
          is_break    <= brk_pending;
          is_extended <= ext_pending;
          code_valid  <= 1'b1;
          ext_pending <= 1'b0;
          brk_pending <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
module tb_ps2_scancode_rx;

  localparam int TIMEOUT = 300;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       is_break, is_extended, code_valid, frame_err;

  int vectors = 0;
  int miscompares = 0;

  // Pulse observations from the DUT
  int cv_seen = 0, err_seen = 0, overlap_seen = 0;

  // Reference model state: derived only from the byte-level rules
  int         exp_cv = 0, exp_err = 0;
  logic [7:0] exp_code = 8'h00;
  logic       exp_brk = 1'b0, exp_ext = 1'b0;
  logic       m_brk = 1'b0, m_ext = 1'b0;

  ps2_scancode_rx #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .scan_code(scan_code), .is_break(is_break), .is_extended(is_extended),
    .code_valid(code_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (code_valid) cv_seen++;
    if (frame_err) err_seen++;
    if (code_valid && frame_err) overlap_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    @(negedge clk);
    check({tag, ".code_valid_count"}, cv_seen, exp_cv);
    check({tag, ".frame_err_count"}, err_seen, exp_err);
    check({tag, ".scan_code"}, {24'd0, scan_code}, {24'd0, exp_code});
    check({tag, ".is_break"}, {31'd0, is_break}, {31'd0, exp_brk});
    check({tag, ".is_extended"}, {31'd0, is_extended}, {31'd0, exp_ext});
    check({tag, ".overlap"}, overlap_seen, 0);
  endtask

  // Model: one completed frame carrying byte b, good when parity and stop are valid
  task automatic model_frame(input logic [7:0] b, input bit good);
    if (!good) begin
      exp_err++; m_brk = 0; m_ext = 0;
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      exp_cv++; exp_code = b; exp_brk = m_brk; exp_ext = m_ext;
      m_brk = 0; m_ext = 0;
    end
  endtask

  task automatic model_reset();
    m_brk = 0; m_ext = 0; exp_code = 8'h00; exp_brk = 0; exp_ext = 0;
  endtask

  task automatic ps2_bit(input logic v);
    int half;
    half = $urandom_range(8, 20);
    ps2_data = v;
    repeat (half) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (half) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  // Frame bit 0 = start, 1..8 = data LSB first, 9 = parity, 10 = stop
  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit flip, input logic stop);
    return {stop, (~^b) ^ flip, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
    repeat (6) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit flip, input logic stop);
    send_bits(make_frame(b, flip, stop), 11);
    model_frame(b, !flip && stop);
  endtask

  initial begin
    logic [7:0] b;
    int r, e;
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (5) @(posedge clk);
    check_all("reset");
    #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    send_byte(8'h1C, 0, 1'b1);  check_all("make_1c");
    send_byte(8'hF0, 0, 1'b1);  check_all("brk_prefix");
    send_byte(8'h1C, 0, 1'b1);  check_all("break_1c");
    send_byte(8'h32, 0, 1'b1);  check_all("make_32");
    send_byte(8'hE0, 0, 1'b1);
    send_byte(8'hF0, 0, 1'b1);
    send_byte(8'h75, 0, 1'b1);  check_all("ext_break_75");
    send_byte(8'h1C, 1, 1'b1);  check_all("parity_err");
    send_byte(8'h21, 0, 1'b1);  check_all("after_parity_21");
    send_byte(8'h2A, 0, 1'b0);  check_all("stop_err");
    send_byte(8'hF0, 0, 1'b1);
    send_byte(8'h2A, 1, 1'b1);  check_all("err_clears_pending");

    // Partial frame: start + 4 data bits, then the line goes quiet
    send_bits(make_frame(8'h1C, 0, 1'b1), 5);
    repeat (TIMEOUT + 20) @(posedge clk);
    exp_err++; m_brk = 0; m_ext = 0;
    check_all("timeout");
    send_byte(8'h32, 0, 1'b1);  check_all("after_timeout_32");

    // Reset during bit 5 of a frame
    send_bits(make_frame(8'h4D, 0, 1'b1), 6);
    #2 rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    check_all("mid_frame_reset");
    #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    send_byte(8'h24, 0, 1'b1);  check_all("after_reset_24");

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      e = $urandom_range(0, 9);
      b = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom_range(0, 255));
      send_byte(b, e == 0, (e == 1) ? 1'b0 : 1'b1);
      check_all($sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule
